icache_tag_array_multiway: RTL and testbench

- N-way set-associative tag store for the instruction cache.
- Holds per-way tags and valid bits, compares a lookup tag against all ways of a set, and reports hit, hit way and replacement victim one cycle later.
- Accepts refill writes from the refill controller and runs a sequential flush of all valid bits.
- Sits between the icache controller (lookup/refill) and the cluster flush/invalidate logic.

---
 rtl/icache_tag_array_multiway.sv | 169 ++++++++++++++++
 tb/tb_icache_tag_array_multiway.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_array_multiway.sv
// rtl/icache_tag_array_multiway.sv - N-way set-associative icache tag store with lookup, refill and flush
module icache_tag_array_multiway #(
    parameter int NB_WAYS        = 4,
    parameter int SET_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lookup_req,
    output logic                      lookup_gnt,
    input  logic [SET_ADDR_WIDTH-1:0] lookup_set,
    input  logic [TAG_WIDTH-1:0]      lookup_tag,
    output logic                      lookup_rvalid,
    output logic                      lookup_hit,
    output logic [NB_WAYS-1:0]        lookup_hit_way,
    output logic [NB_WAYS-1:0]        lookup_victim_way,
    output logic                      lookup_multi_hit,
    input  logic                      refill_req,
    output logic                      refill_gnt,
    input  logic [SET_ADDR_WIDTH-1:0] refill_set,
    input  logic [NB_WAYS-1:0]        refill_way,
    input  logic [TAG_WIDTH-1:0]      refill_tag,
    input  logic                      flush_req,
    output logic                      flush_busy,
    output logic                      flush_done
);

    localparam int NB_SETS = 2 ** SET_ADDR_WIDTH;
    localparam int PTR_W   = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [SET_ADDR_WIDTH-1:0] flush_cnt;
    logic [NB_WAYS-1:0]        valid_q [NB_SETS];
    logic [TAG_WIDTH-1:0]      tag_q   [NB_SETS][NB_WAYS];
    logic [PTR_W-1:0]          rr_ptr;

    logic                      refill_legal;
    logic                      refill_we;
    logic [NB_WAYS-1:0]        hit_vec;
    logic [NB_WAYS-1:0]        victim_vec;
    logic                      multi_vec;

    // Next state and grants; a flush request in IDLE blocks both grants that cycle
    always_comb begin
        state_nxt  = state;
        lookup_gnt = 1'b0;
        refill_gnt = 1'b0;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else begin
                    lookup_gnt = lookup_req;
                    refill_gnt = refill_req;
                end
            end
            FLUSH: begin
                flush_busy = 1'b1;
                if (flush_cnt == SET_ADDR_WIDTH'(NB_SETS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and flush set counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + SET_ADDR_WIDTH'(1);
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    // Only a one-hot way select is a legal refill
    always_comb begin
        refill_legal = (refill_way != '0) &&
                       ((refill_way & (refill_way - NB_WAYS'(1))) == '0);
        refill_we    = refill_gnt && refill_legal;
    end

    // Valid bits: flush clears one set per cycle, refill sets the selected way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NB_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (state == FLUSH) begin
            valid_q[flush_cnt] <= '0;
        end else if (refill_we) begin
            valid_q[refill_set] <= valid_q[refill_set] | refill_way;
        end
    end

    // Tag storage, written only by legal refills; contents need no reset
    always_ff @(posedge clk) begin
        if (refill_we) begin
            for (int w = 0; w < NB_WAYS; w++) begin
                if (refill_way[w]) begin
                    tag_q[refill_set][w] <= refill_tag;
                end
            end
        end
    end

    // Round-robin victim pointer advances on every legal refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (refill_we) begin
            rr_ptr <= (NB_WAYS == 1) ? '0 : rr_ptr + PTR_W'(1);
        end
    end

    // Tag compare and victim choice on pre-write contents of the looked-up set
    always_comb begin
        hit_vec    = '0;
        victim_vec = NB_WAYS'(1) << rr_ptr;
        for (int w = 0; w < NB_WAYS; w++) begin
            hit_vec[w] = valid_q[lookup_set][w] && (tag_q[lookup_set][w] == lookup_tag);
        end
        for (int w = NB_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lookup_set][w]) begin
                victim_vec = NB_WAYS'(1) << w;
            end
        end
        multi_vec = (hit_vec & (hit_vec - NB_WAYS'(1))) != '0;
    end

    // Registered lookup response, zeroed when no lookup was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_rvalid     <= 1'b0;
            lookup_hit        <= 1'b0;
            lookup_hit_way    <= '0;
            lookup_victim_way <= '0;
            lookup_multi_hit  <= 1'b0;
        end else if (lookup_gnt) begin
            lookup_rvalid     <= 1'b1;
            lookup_hit        <= |hit_vec;
            lookup_hit_way    <= hit_vec;
            lookup_victim_way <= victim_vec;
            lookup_multi_hit  <= multi_vec;
        end else begin
            lookup_rvalid     <= 1'b0;
            lookup_hit        <= 1'b0;
            lookup_hit_way    <= '0;
            lookup_victim_way <= '0;
            lookup_multi_hit  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_icache_tag_array_multiway.sv
// tb/tb_icache_tag_array_multiway.sv - directed self-checking bench for icache_tag_array_multiway
module tb_icache_tag_array_multiway;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lookup_req = 1'b0;
    logic       lookup_gnt;
    logic [5:0] lookup_set = '0;
    logic [6:0] lookup_tag = '0;
    logic       lookup_rvalid;
    logic       lookup_hit;
    logic [3:0] lookup_hit_way;
    logic [3:0] lookup_victim_way;
    logic       lookup_multi_hit;
    logic       refill_req = 1'b0;
    logic       refill_gnt;
    logic [5:0] refill_set = '0;
    logic [3:0] refill_way = '0;
    logic [6:0] refill_tag = '0;
    logic       flush_req = 1'b0;
    logic       flush_busy;
    logic       flush_done;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;
    int done_cnt;
    int gnt_bad;

    icache_tag_array_multiway dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lookup_req        (lookup_req),
        .lookup_gnt        (lookup_gnt),
        .lookup_set        (lookup_set),
        .lookup_tag        (lookup_tag),
        .lookup_rvalid     (lookup_rvalid),
        .lookup_hit        (lookup_hit),
        .lookup_hit_way    (lookup_hit_way),
        .lookup_victim_way (lookup_victim_way),
        .lookup_multi_hit  (lookup_multi_hit),
        .refill_req        (refill_req),
        .refill_gnt        (refill_gnt),
        .refill_set        (refill_set),
        .refill_way        (refill_way),
        .refill_tag        (refill_tag),
        .flush_req         (flush_req),
        .flush_busy        (flush_busy),
        .flush_done        (flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_req = 1'b0;
        refill_req = 1'b0;
        flush_req  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic refill(input logic [5:0] s, input logic [3:0] w, input logic [6:0] t);
        refill_req = 1'b1;
        refill_set = s;
        refill_way = w;
        refill_tag = t;
        tick();
        refill_req = 1'b0;
    endtask

    task automatic lookup(input logic [5:0] s, input logic [6:0] t);
        lookup_req = 1'b1;
        lookup_set = s;
        lookup_tag = t;
        tick();
        lookup_req = 1'b0;
    endtask

    initial begin
        // 1: reset state and first miss
        do_reset();
        chk("rst_rvalid", lookup_rvalid, 0);
        chk("rst_hit", lookup_hit, 0);
        chk("rst_hit_way", lookup_hit_way, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_done", flush_done, 0);
        lookup_req = 1'b1; lookup_set = 6'd5; lookup_tag = 7'h12;
        #1;
        chk("t1_gnt", lookup_gnt, 1);
        tick();
        lookup_req = 1'b0;
        chk("t1_rvalid", lookup_rvalid, 1);
        chk("t1_hit", lookup_hit, 0);
        chk("t1_victim", lookup_victim_way, 4'b0001);
        tick();
        chk("t1_rvalid_drop", lookup_rvalid, 0);

        // 2: refill then hit / miss on different tag
        refill_req = 1'b1; refill_set = 6'd5; refill_way = 4'b0100; refill_tag = 7'h12;
        #1;
        chk("t2_refill_gnt", refill_gnt, 1);
        tick();
        refill_req = 1'b0;
        lookup(6'd5, 7'h12);
        chk("t2_hit", lookup_hit, 1);
        chk("t2_hit_way", lookup_hit_way, 4'b0100);
        chk("t2_victim", lookup_victim_way, 4'b0001);
        chk("t2_multi", lookup_multi_hit, 0);
        lookup(6'd5, 7'h13);
        chk("t2_miss", lookup_hit, 0);
        chk("t2_miss_way", lookup_hit_way, 0);

        // 3: round-robin victim, illegal refills, multi-hit
        do_reset();
        refill(6'd9, 4'b0001, 7'h20);
        refill(6'd9, 4'b0010, 7'h21);
        refill(6'd9, 4'b0100, 7'h22);
        refill(6'd9, 4'b1000, 7'h23);
        refill(6'd9, 4'b0001, 7'h30);
        lookup(6'd9, 7'h7f);
        chk("t3_miss", lookup_hit, 0);
        chk("t3_victim_rr", lookup_victim_way, 4'b0010);
        lookup(6'd9, 7'h21);
        chk("t3_hit_way", lookup_hit_way, 4'b0010);
        refill(6'd9, 4'b0011, 7'h7f);
        refill(6'd9, 4'b0000, 7'h7f);
        lookup(6'd9, 7'h7f);
        chk("t3_illegal_nowrite", lookup_hit, 0);
        chk("t3_illegal_noptr", lookup_victim_way, 4'b0010);
        refill(6'd9, 4'b0100, 7'h30);
        lookup(6'd9, 7'h30);
        chk("t3_multi_way", lookup_hit_way, 4'b0101);
        chk("t3_multi", lookup_multi_hit, 1);
        chk("t3_victim_rr2", lookup_victim_way, 4'b0100);

        // 4: same-cycle lookup and refill sees old contents
        lookup_req = 1'b1; lookup_set = 6'd3; lookup_tag = 7'h44;
        refill_req = 1'b1; refill_set = 6'd3; refill_way = 4'b0001; refill_tag = 7'h44;
        tick();
        refill_req = 1'b0;
        chk("t4_rbw_miss", lookup_hit, 0);
        chk("t4_rbw_victim", lookup_victim_way, 4'b0001);
        tick();
        lookup_req = 1'b0;
        chk("t4_repeat_hit", lookup_hit, 1);
        chk("t4_repeat_way", lookup_hit_way, 4'b0001);

        // 5: full flush
        refill(6'd0, 4'b0001, 7'h01);
        refill(6'd63, 4'b1000, 7'h02);
        lookup(6'd63, 7'h02);
        chk("t5_prehit", lookup_hit, 1);
        flush_req = 1'b1;
        lookup_req = 1'b1; lookup_set = 6'd0; lookup_tag = 7'h01;
        refill_req = 1'b1; refill_set = 6'd1; refill_way = 4'b0001; refill_tag = 7'h05;
        #1;
        chk("t5_prio_lgnt", lookup_gnt, 0);
        chk("t5_prio_rgnt", refill_gnt, 0);
        tick();
        flush_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; gnt_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (flush_busy) busy_cnt++;
            if (flush_done) done_cnt++;
            if (lookup_gnt || refill_gnt) gnt_bad++;
            if (flush_done) break;
            flush_req = (i == 10);
            tick();
        end
        idle_inputs();
        chk("t5_busy_cycles", busy_cnt, 64);
        chk("t5_done_pulses", done_cnt, 1);
        chk("t5_gnt_blocked", gnt_bad, 0);
        tick();
        chk("t5_done_clear", flush_done, 0);
        chk("t5_busy_clear", flush_busy, 0);
        lookup(6'd0, 7'h01);
        chk("t5_set0_miss", lookup_hit, 0);
        chk("t5_set0_victim", lookup_victim_way, 4'b0001);
        lookup(6'd63, 7'h02);
        chk("t5_set63_miss", lookup_hit, 0);
        lookup(6'd1, 7'h05);
        chk("t5_blocked_refill", lookup_hit, 0);

        // 6: reset aborts flush at counter 20
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (20) tick();
        chk("t6_busy_pre", flush_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_abort", flush_busy, 0);
        chk("t6_done_abort", flush_done, 0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush_done || flush_busy) done_cnt++;
        end
        chk("t6_no_done", done_cnt, 0);
        lookup_req = 1'b1; refill_req = 1'b1; refill_way = 4'b0010;
        #1;
        chk("t6_lgnt", lookup_gnt, 1);
        chk("t6_rgnt", refill_gnt, 1);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
